// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 stream engine.
package rc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_KSA  = 3'd3,
    ST_DROP = 3'd4,
    ST_RUN  = 3'd5
  } state_t;

  localparam int SBOX_DEPTH = 256;
  localparam int DROP_W     = 12;

  function automatic logic key_len_ok(input int unsigned len, input int unsigned key_max);
    return (len >= 1) && (len <= key_max);
  endfunction

endpackage

// File: rtl/rc4_key_buf.sv
// Key register file: serial write during LOAD, wrapping read index during KSA.
module rc4_key_buf import rc4_pkg::*; #(
  parameter int KEY_MAX = 16,
  parameter int KLW     = $clog2(KEY_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  input  logic           rd_adv,
  input  logic [KLW-1:0] key_len,
  output logic           last_wr,
  output logic [7:0]     rd_data
);

  localparam int IW    = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int DEPTH = 1 << IW;

  logic [7:0]     mem [DEPTH];
  logic [KLW-1:0] wptr;
  logic [KLW-1:0] ridx;
  logic [KLW-1:0] klast;

  assign klast   = key_len - KLW'(1);
  assign last_wr = (wptr == klast);
  assign rd_data = mem[ridx[IW-1:0]];

  // ridx wraps at key_len-1 so it always equals i mod key_len during KSA
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < DEPTH; c++) mem[c] <= '0;
      wptr <= '0;
      ridx <= '0;
    end else if (clr) begin
      wptr <= '0;
      ridx <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[IW-1:0]] <= wr_data;
        wptr <= wptr + KLW'(1);
      end
      if (rd_adv) ridx <= (ridx == klast) ? '0 : ridx + KLW'(1);
    end
  end

endmodule

// File: rtl/rc4_stream_core.sv
// RC4 engine: key load, S-box init, KSA, optional drop, then byte-stream XOR.
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting key bytes
// INIT  | S[c] = c, one entry per cycle
// KSA   | key scheduling, one swap per cycle
// DROP  | discarding DROP_N keystream bytes
// RUN   | one keystream byte per accepted din
module rc4_stream_core import rc4_pkg::*; #(
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 0,
  parameter int KLW     = $clog2(KEY_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [KLW-1:0] key_len,
  input  logic           key_valid,
  input  logic [7:0]     key_byte,
  output logic           key_ready,
  input  logic           din_valid,
  input  logic [7:0]     din,
  output logic           din_ready,
  output logic           dout_valid,
  output logic [7:0]     dout,
  input  logic           dout_ready,
  output logic           keyed,
  output logic           busy,
  output logic           err,
  output logic [2:0]     phase
);

  localparam logic [DROP_W-1:0] DROP_LD = DROP_W'(DROP_N);

  state_t              state;
  logic [7:0]          sbox [SBOX_DEPTH];
  logic [7:0]          i_q, j_q;
  logic [KLW-1:0]      klen;
  logic [DROP_W-1:0]   drop_cnt;
  logic [7:0]          k_byte;
  logic                key_last, key_wr, key_adv, start_ok, din_fire, step;
  logic [7:0]          ksa_j, pi, psi, pj, psj, pt, ks;

  assign start_ok  = key_len_ok(32'(key_len), KEY_MAX);
  assign key_ready = (state == ST_LOAD);
  assign keyed     = (state == ST_RUN);
  assign busy      = (state == ST_LOAD) || (state == ST_INIT) ||
                     (state == ST_KSA)  || (state == ST_DROP);
  assign phase     = state;
  assign din_ready = (state == ST_RUN) && (!dout_valid || dout_ready);
  assign key_wr    = key_valid && key_ready && !start;
  assign key_adv   = (state == ST_KSA) && !start;
  assign din_fire  = din_valid && din_ready && !start;
  assign step      = !start && ((state == ST_DROP) || din_fire);

  rc4_key_buf #(.KEY_MAX(KEY_MAX), .KLW(KLW)) u_key_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .wr_en   (key_wr),
    .wr_data (key_byte),
    .rd_adv  (key_adv),
    .key_len (klen),
    .last_wr (key_last),
    .rd_data (k_byte)
  );

  // ks must see the post-swap S-box, so forward when t hits i or j
  always_comb begin
    ksa_j = j_q + sbox[i_q] + k_byte;
    pi    = i_q + 8'd1;
    psi   = sbox[pi];
    pj    = j_q + psi;
    psj   = sbox[pj];
    pt    = psi + psj;
    if (pt == pi)      ks = psj;
    else if (pt == pj) ks = psi;
    else               ks = sbox[pt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < SBOX_DEPTH; c++) sbox[c] <= '0;
    end else if (!start) begin
      if (state == ST_INIT) begin
        sbox[i_q] <= i_q;
      end else if (state == ST_KSA) begin
        sbox[i_q]   <= sbox[ksa_j];
        sbox[ksa_j] <= sbox[i_q];
      end else if (step) begin
        sbox[pi] <= psj;
        sbox[pj] <= psi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      klen       <= '0;
      drop_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else if (start) begin
      dout_valid <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      if (start_ok) begin
        state <= ST_LOAD;
        klen  <= key_len;
        err   <= 1'b0;
      end else begin
        state <= ST_IDLE;
        err   <= 1'b1;
      end
    end else begin
      case (state)
        ST_LOAD: if (key_wr && key_last) state <= ST_INIT;
        ST_INIT: begin
          i_q <= i_q + 8'd1;
          if (i_q == 8'hFF) begin
            j_q   <= '0;
            state <= ST_KSA;
          end
        end
        ST_KSA: begin
          i_q <= i_q + 8'd1;
          j_q <= ksa_j;
          if (i_q == 8'hFF) begin
            j_q      <= '0;
            drop_cnt <= DROP_LD;
            state    <= (DROP_N > 0) ? ST_DROP : ST_RUN;
          end
        end
        ST_DROP: begin
          i_q      <= pi;
          j_q      <= pj;
          drop_cnt <= drop_cnt - DROP_W'(1);
          if (drop_cnt == DROP_W'(1)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (din_fire) begin
            i_q        <= pi;
            j_q        <= pj;
            dout       <= din ^ ks;
            dout_valid <= 1'b1;
          end else if (dout_ready) begin
            dout_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_core.sv
// Directed bench: known RC4 vectors, drop variant, stalls, aborts, err and reset.
module tb_rc4_stream_core;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start1 = 1'b0;
  logic [4:0] key_len = '0;
  logic       key_valid = 1'b0;
  logic [7:0] key_byte = '0;
  logic       din_valid = 1'b0, din_valid1 = 1'b0;
  logic [7:0] din = '0;
  logic       dout_ready = 1'b0;

  logic       key_ready0, din_ready0, dout_valid0, keyed0, busy0, err0;
  logic [7:0] dout0;
  logic [2:0] phase0;
  logic       key_ready1, din_ready1, dout_valid1, keyed1, busy1, err1;
  logic [7:0] dout1;
  logic [2:0] phase1;

  int   n_cmp = 0;
  int   n_fail = 0;
  bq_t  exp0, exp1;
  logic stall0 = 1'b0, stall1 = 1'b0;
  logic [7:0] held0 = '0, held1 = '0;

  rc4_stream_core #(.KEY_MAX(16), .DROP_N(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len),
    .key_valid(key_valid), .key_byte(key_byte), .key_ready(key_ready0),
    .din_valid(din_valid), .din(din), .din_ready(din_ready0),
    .dout_valid(dout_valid0), .dout(dout0), .dout_ready(dout_ready),
    .keyed(keyed0), .busy(busy0), .err(err0), .phase(phase0)
  );

  rc4_stream_core #(.KEY_MAX(16), .DROP_N(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_len(key_len),
    .key_valid(key_valid), .key_byte(key_byte), .key_ready(key_ready1),
    .din_valid(din_valid1), .din(din), .din_ready(din_ready1),
    .dout_valid(dout_valid1), .dout(dout1), .dout_ready(dout_ready),
    .keyed(keyed1), .busy(busy1), .err(err1), .phase(phase1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    return q;
  endfunction

  function automatic bq_t rc4_ks(input bq_t key, input int n);
    logic [7:0] s [256];
    logic [7:0] a, b, t;
    bq_t q;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    b = 0;
    for (int k = 0; k < 256; k++) begin
      b = b + s[k] + key[k % key.size()];
      t = s[k]; s[k] = s[b]; s[b] = t;
    end
    a = 0; b = 0;
    for (int k = 0; k < n; k++) begin
      a = a + 1; b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      q.push_back(s[8'(s[a] + s[b])]);
    end
    return q;
  endfunction

  // Scoreboard pop and hold check, sampled on the falling edge
  task automatic mon();
    logic [7:0] e;
    if (rst) begin
      if (dout_valid0 && dout_ready) begin
        if (exp0.size() == 0) chk("dout0_extra", exp0.size(), 1);
        else begin e = exp0.pop_front(); chk("dout0", dout0, e); end
      end
      if (stall0 && dout_valid0) chk("dout0_hold", dout0, held0);
      stall0 = dout_valid0 && !dout_ready;
      held0  = dout0;
      if (dout_valid1 && dout_ready) begin
        if (exp1.size() == 0) chk("dout1_extra", exp1.size(), 1);
        else begin e = exp1.pop_front(); chk("dout1", dout1, e); end
      end
      if (stall1 && dout_valid1) chk("dout1_hold", dout1, held1);
      stall1 = dout_valid1 && !dout_ready;
      held1  = dout1;
    end else begin
      stall0 = 1'b0;
      stall1 = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input int which, input int len);
    key_len = 5'(len);
    if (which == 1) start1 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic load_key(input int which, input bq_t k);
    int n = 0, g = 0;
    logic acc;
    key_valid = 1'b1;
    while (n < k.size() && g < 200) begin
      key_byte = k[n];
      #1;
      acc = (which == 1) ? key_ready1 : key_ready0;
      tick();
      if (acc) n++;
      g++;
    end
    key_valid = 1'b0;
    chk("key_bytes_loaded", n, k.size());
  endtask

  task automatic wait_keyed(input int which, input int cyc, input string tag);
    int c = 0;
    while (!((which == 1) ? keyed1 : keyed0) && c < 5000) begin
      tick();
      c++;
    end
    chk(tag, c, cyc);
  endtask

  task automatic send(input int which, input bq_t data, input bq_t expq, input bit stalls);
    int n = 0, g = 0;
    logic v, acc;
    while (n < data.size() && g < 2000) begin
      din = data[n];
      v = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (which == 1) din_valid1 = v; else din_valid = v;
      dout_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      acc = v && ((which == 1) ? din_ready1 : din_ready0);
      if (acc) begin
        if (which == 1) exp1.push_back(expq[n]); else exp0.push_back(expq[n]);
        n++;
      end
      tick();
      g++;
    end
    din_valid = 1'b0;
    din_valid1 = 1'b0;
    dout_ready = 1'b1;
    chk("bytes_sent", n, data.size());
    g = 0;
    while (((which == 1) ? exp1.size() : exp0.size()) != 0 && g < 200) begin
      tick();
      g++;
    end
    chk("drain", (which == 1) ? exp1.size() : exp0.size(), 0);
  endtask

  initial begin
    bq_t k_key, k_wiki, k_sec, k_nums, zeros, full, tail;
    bq_t e_key, e_wiki, e_sec, e_nums;
    k_key  = str2q("Key");
    k_wiki = str2q("Wiki");
    k_sec  = str2q("Secret");
    k_nums = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    e_key  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    e_wiki = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    e_sec  = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
               8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    e_nums = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27,
               8'hCC, 8'hC3, 8'h52, 8'h4A, 8'h0A, 8'h11, 8'h18, 8'hA8};
    for (int k = 0; k < 16; k++) zeros.push_back(8'h00);

    #2 rst = 1'b0;
    #2;
    chk("reset_outs0", {key_ready0, din_ready0, dout_valid0, keyed0, busy0, err0, phase0, dout0}, 0);
    chk("reset_outs1", {key_ready1, din_ready1, dout_valid1, keyed1, busy1, err1, phase1, dout1}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("idle_phase", phase0, 0);

    // Key / Plaintext
    start_key(0, 3);
    chk("load_phase", phase0, 1);
    chk("load_busy_kready", {busy0, key_ready0, keyed0}, 3'b110);
    load_key(0, k_key);
    wait_keyed(0, 512, "rekey_latency");
    send(0, str2q("Plaintext"), e_key, 1'b0);

    start_key(0, 4);
    load_key(0, k_wiki);
    wait_keyed(0, 512, "rekey_latency_wiki");
    send(0, str2q("pedia"), e_wiki, 1'b0);

    start_key(0, 6);
    load_key(0, k_sec);
    wait_keyed(0, 512, "rekey_latency_secret");
    send(0, str2q("Attack at dawn"), e_sec, 1'b0);

    start_key(0, 5);
    load_key(0, k_nums);
    wait_keyed(0, 512, "rekey_latency_nums");
    send(0, zeros, e_nums, 1'b0);

    // Drop variant: output must be bytes 16..31 of the undropped stream
    full = rc4_ks(k_nums, 32);
    for (int k = 16; k < 32; k++) tail.push_back(full[k]);
    start_key(1, 5);
    load_key(1, k_nums);
    wait_keyed(1, 528, "rekey_latency_drop16");
    send(1, zeros, tail, 1'b0);

    // Illegal key lengths, then a legal start clears err
    start_key(0, 0);
    chk("err_len0", {err0, phase0}, 4'b1000);
    start_key(0, 17);
    chk("err_len17", {err0, phase0, busy0}, 5'b10000);
    start_key(0, 3);
    chk("err_cleared", {err0, phase0}, 4'b0001);
    load_key(0, k_key);
    wait_keyed(0, 512, "rekey_latency_stall");
    send(0, str2q("Plaintext"), e_key, 1'b1);

    // Abort mid-KSA
    start_key(0, 3);
    load_key(0, k_key);
    repeat (300) tick();
    chk("mid_ksa_phase", phase0, 3);
    start_key(0, 4);
    chk("restart_phase", phase0, 1);
    load_key(0, k_wiki);
    wait_keyed(0, 512, "rekey_after_ksa_abort");
    send(0, str2q("pedia"), e_wiki, 1'b0);

    // Abort mid-RUN with a stalled output
    dout_ready = 1'b0;
    din = 8'h55;
    din_valid = 1'b1;
    #1;
    chk("run_din_ready", din_ready0, 1);
    tick();
    din_valid = 1'b0;
    chk("stalled_state", {dout_valid0, din_ready0}, 2'b10);
    start_key(0, 3);
    chk("abort_clears_dout_valid", {dout_valid0, phase0}, 4'b0001);
    load_key(0, k_key);
    wait_keyed(0, 512, "rekey_after_run_abort");
    send(0, str2q("Plaintext"), e_key, 1'b0);

    // Async reset mid-RUN with a pending output
    dout_ready = 1'b0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("pre_reset_valid", {dout_valid0, keyed0}, 2'b11);
    rst = 1'b0;
    #1;
    chk("async_reset_outs", {key_ready0, din_ready0, dout_valid0, keyed0, busy0, err0, phase0, dout0}, 0);
    exp0.delete();
    exp1.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    dout_ready = 1'b1;
    tick();
    chk("post_reset_phase", {phase0, dout_valid0}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
